axis_pixels_dw_upsizer: RTL and testbench

- Packs the narrow DMA pixel stream into the wide pixel bus of width S_PIXELS_WIDTH_LF.
- Sits directly upstream of the pixel input of the input pipe: its m_axis_* ports drive s_axis_pixels_t* there.
- Accumulates R = M_WORDS/S_WORDS input beats per output beat.
- tlast flushes a partial word, with unfilled lanes zero and their keep bits zero.

---
 rtl/axis_pixels_dw_upsizer.sv | 98 +++++++++
 tb/tb_axis_pixels_dw_upsizer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pixels_dw_upsizer.sv
// Packs narrow DMA pixel beats into the wide pixel bus, R input beats per output word.
// tlast flushes a partial word with the unfilled lanes (data and keep) zeroed.

`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef S_PIXELS_WIDTH_LF
`define S_PIXELS_WIDTH_LF 256
`endif

module axis_pixels_dw_upsizer #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int S_WORDS    = 8,
  parameter int M_WORDS    = `S_PIXELS_WIDTH_LF / `WORD_WIDTH
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic [S_WORDS*WORD_WIDTH-1:0] s_axis_tdata,
  input  logic [S_WORDS-1:0]            s_axis_tkeep,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [M_WORDS*WORD_WIDTH-1:0] m_axis_tdata,
  output logic [M_WORDS-1:0]            m_axis_tkeep
);

  localparam int R      = M_WORDS / S_WORDS;
  localparam int BITS_R = (R > 1) ? $clog2(R) : 1;
  localparam int SLICE  = S_WORDS * WORD_WIDTH;
  localparam logic [BITS_R-1:0] LAST_CNT = BITS_R'(R - 1);

  if (R < 1 || (M_WORDS % S_WORDS) != 0) begin : g_bad_ratio
    $error("axis_pixels_dw_upsizer: M_WORDS must be a positive multiple of S_WORDS");
  end

  logic [BITS_R-1:0]             cnt;
  logic [M_WORDS*WORD_WIDTH-1:0] acc_data;
  logic [M_WORDS-1:0]            acc_keep;
  logic [M_WORDS*WORD_WIDTH-1:0] merge_data;
  logic [M_WORDS-1:0]            merge_keep;
  logic                          acc_beat;
  logic                          out_beat;
  logic                          complete;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign acc_beat      = s_axis_tvalid && s_axis_tready;
  assign out_beat      = m_axis_tvalid && m_axis_tready;
  assign complete      = acc_beat && (cnt == LAST_CNT || s_axis_tlast);

  // Slots below cnt keep accumulated beats, slot cnt takes the live beat, slots above stay zero.
  always_comb begin
    merge_data = '0;
    merge_keep = '0;
    for (int b = 0; b < R; b++) begin
      if (b == int'(cnt)) begin
        merge_data[b*SLICE +: SLICE]     = s_axis_tdata;
        merge_keep[b*S_WORDS +: S_WORDS] = s_axis_tkeep;
      end else if (b < int'(cnt)) begin
        merge_data[b*SLICE +: SLICE]     = acc_data[b*SLICE +: SLICE];
        merge_keep[b*S_WORDS +: S_WORDS] = acc_keep[b*S_WORDS +: S_WORDS];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt           <= '0;
      acc_data      <= '0;
      acc_keep      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
    end else if (complete) begin
      // A completing beat can land while the previous word is being taken, so valid stays high.
      m_axis_tdata  <= merge_data;
      m_axis_tkeep  <= merge_keep;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tvalid <= 1'b1;
      cnt           <= '0;
      acc_data      <= '0;
      acc_keep      <= '0;
    end else begin
      if (out_beat) begin
        m_axis_tvalid <= 1'b0;
      end
      if (acc_beat) begin
        acc_data <= merge_data;
        acc_keep <= merge_keep;
        cnt      <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pixels_dw_upsizer.sv
// Bench for axis_pixels_dw_upsizer at 8-bit words, 2 words in, 8 words out (R=4).
// A lane-list model builds expected output words; directed cases add fixed expectations.

module tb_axis_pixels_dw_upsizer;

  localparam int WW = 8;
  localparam int SW = 2;
  localparam int MW = 8;

  typedef struct packed {
    logic [MW*WW-1:0] data;
    logic [MW-1:0]    keep;
    logic             last;
  } outWord_t;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic [SW*WW-1:0]  s_axis_tdata = '0;
  logic [SW-1:0]     s_axis_tkeep = '0;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic [MW*WW-1:0]  m_axis_tdata;
  logic [MW-1:0]     m_axis_tkeep;

  int checks = 0;
  int failures = 0;
  int outCount = 0;

  outWord_t expQ[$];
  logic [WW-1:0] partWords[$];
  logic          partKeep[$];
  outWord_t newest;
  outWord_t held;
  outWord_t lastOut;
  logic expectNew = 1'b0;
  logic holdPrev = 1'b0;
  logic checkResetNext = 1'b0;

  axis_pixels_dw_upsizer #(
    .WORD_WIDTH(WW),
    .S_WORDS(SW),
    .M_WORDS(MW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_tready(s_axis_tready),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Each accepted beat appends its lanes; a full word or tlast closes the word, zero-padded.
  task automatic modelBeat(input logic [SW*WW-1:0] d, input logic [SW-1:0] k, input logic l);
    outWord_t w;
    for (int i = 0; i < SW; i++) begin
      partWords.push_back(d[i*WW +: WW]);
      partKeep.push_back(k[i]);
    end
    if (partWords.size() == MW || l) begin
      w = '0;
      for (int lane = 0; lane < MW; lane++) begin
        if (lane < partWords.size()) begin
          w.data[lane*WW +: WW] = partWords[lane];
          w.keep[lane]          = partKeep[lane];
        end
      end
      w.last = l;
      partWords.delete();
      partKeep.delete();
      expQ.push_back(w);
      newest    = w;
      expectNew = 1'b1;
    end
  endtask

  always @(negedge aclk) begin
    outWord_t got;
    outWord_t exp;
    if (!aresetn) begin
      expQ.delete();
      partWords.delete();
      partKeep.delete();
      expectNew      = 1'b0;
      holdPrev       = 1'b0;
      checkResetNext = 1'b1;
    end else begin
      got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (checkResetNext) begin
        checkOutput("reset_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("reset_last", 64'(m_axis_tlast), 64'd0);
        checkOutput("reset_data", m_axis_tdata, 64'd0);
        checkOutput("reset_keep", 64'(m_axis_tkeep), 64'd0);
        checkResetNext = 1'b0;
      end
      if (expectNew) begin
        checkOutput("latency_valid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("latency_data", m_axis_tdata, newest.data);
        expectNew = 1'b0;
      end
      if (holdPrev) begin
        checkOutput("hold_valid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("hold_data", m_axis_tdata, held.data);
        checkOutput("hold_keep_last", 64'({m_axis_tkeep, m_axis_tlast}), 64'({held.keep, held.last}));
      end
      checkOutput("s_ready", 64'(s_axis_tready), 64'(!m_axis_tvalid || m_axis_tready));
      if (m_axis_tvalid && m_axis_tready) begin
        outCount++;
        lastOut = got;
        if (expQ.size() == 0) begin
          checkOutput("spurious_output", 64'(m_axis_tvalid), 64'd0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("out_data", m_axis_tdata, exp.data);
          checkOutput("out_keep_last", 64'({m_axis_tkeep, m_axis_tlast}), 64'({exp.keep, exp.last}));
        end
      end
      holdPrev = m_axis_tvalid && !m_axis_tready;
      held     = got;
      if (s_axis_tvalid && s_axis_tready) begin
        modelBeat(s_axis_tdata, s_axis_tkeep, s_axis_tlast);
      end
    end
  end

  // Present one beat and keep it up until it is accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [SW*WW-1:0] d, input logic [SW-1:0] k, input logic l);
    logic accepted;
    int waitCnt;
    accepted      = 1'b0;
    waitCnt       = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!accepted && waitCnt < 200) begin
      @(negedge aclk);
      accepted = s_axis_tready;
      @(posedge aclk);
      #1;
      waitCnt++;
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 64'(accepted), 64'd1);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    int startCount;
    time t0;
    logic randDone;
    int waitCnt;

    aresetn = 1'b0;
    idle(3);
    aresetn = 1'b1;
    idle(2);

    applyStimulus(16'h0201, 2'b11, 1'b0);
    applyStimulus(16'h0403, 2'b11, 1'b0);
    applyStimulus(16'h0605, 2'b11, 1'b0);
    applyStimulus(16'h0807, 2'b11, 1'b1);
    idle(2);
    checkOutput("full_data", lastOut.data, 64'h0807060504030201);
    checkOutput("full_keep_last", 64'({lastOut.keep, lastOut.last}), 64'({8'hFF, 1'b1}));

    applyStimulus(16'hBBAA, 2'b11, 1'b0);
    applyStimulus(16'hDDCC, 2'b11, 1'b1);
    idle(2);
    checkOutput("flush_data", lastOut.data, 64'h00000000DDCCBBAA);
    checkOutput("flush_keep_last", 64'({lastOut.keep, lastOut.last}), 64'({8'h0F, 1'b1}));

    applyStimulus(16'h2211, 2'b11, 1'b0);
    applyStimulus(16'h4433, 2'b11, 1'b0);
    applyStimulus(16'h6655, 2'b11, 1'b0);
    applyStimulus(16'h8877, 2'b11, 1'b0);
    m_axis_tready = 1'b0;
    startCount = outCount;
    fork
      applyStimulus(16'h55AA, 2'b11, 1'b1);
      begin
        repeat (5) begin
          @(negedge aclk);
          checkOutput("bp_s_ready_low", 64'(s_axis_tready), 64'd0);
          @(posedge aclk);
          #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    checkOutput("bp_taken_once", 64'(outCount - startCount), 64'd1);
    checkOutput("bp_word_data", lastOut.data, 64'h8877665544332211);
    idle(2);
    checkOutput("bp_next_data", lastOut.data, 64'h00000000000055AA);
    checkOutput("bp_next_keep", 64'(lastOut.keep), 64'h03);

    startCount = outCount;
    t0 = $time;
    for (int i = 0; i < 24; i++) begin
      applyStimulus({8'(2*i+1), 8'(2*i)}, 2'b11, (i % 8) == 7);
    end
    checkOutput("stream_cycles", 64'(($time - t0) / 10), 64'd24);
    idle(2);
    checkOutput("stream_outputs", 64'(outCount - startCount), 64'd6);
    checkOutput("stream_last_data", lastOut.data, 64'h2F2E2D2C2B2A2928);
    checkOutput("stream_last_flag", 64'(lastOut.last), 64'd1);

    applyStimulus(16'h0011, 2'b01, 1'b0);
    applyStimulus(16'h0000, 2'b00, 1'b1);
    idle(2);
    checkOutput("oddkeep_data", lastOut.data, 64'h0000000000000011);
    checkOutput("oddkeep_keep", 64'(lastOut.keep), 64'h01);

    startCount = outCount;
    applyStimulus(16'hDEAD, 2'b11, 1'b0);
    applyStimulus(16'hBEEF, 2'b11, 1'b0);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h1111, 2'b11, 1'b0);
    end
    idle(2);
    checkOutput("rst_outputs", 64'(outCount - startCount), 64'd1);
    checkOutput("rst_data", lastOut.data, 64'h1111111111111111);
    checkOutput("rst_keep", 64'(lastOut.keep), 64'hFF);

    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          applyStimulus(16'($urandom), 2'($urandom), $urandom_range(0, 3) == 0);
          if ($urandom_range(0, 4) == 0) idle(1);
        end
        applyStimulus(16'($urandom), 2'($urandom), 1'b1);
        s_axis_tvalid = 1'b0;
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge aclk);
          #1;
          if (!randDone) m_axis_tready = $urandom_range(0, 3) != 0;
        end
        m_axis_tready = 1'b1;
      end
    join

    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 500) begin
      idle(1);
      waitCnt++;
    end
    idle(2);
    checkOutput("queue_drain", 64'(expQ.size()), 64'd0);
    checkOutput("final_valid", 64'(m_axis_tvalid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
